// File: rtl/zint_ack_pkg.sv
// Shared definitions for the Z80 IM2 interrupt responder (zint_ack).
// Holds the state encodings, the RETI opcode bytes and the default sizes.
package zint_ack_pkg;

    // Default number of sources and index width (clog2 of the source count)
    localparam int NSRC_DEF = 4;
    localparam int IDXW_DEF = 2;

    // Main acknowledge FSM
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_DONE = 2'd2
    } ack_state_t;

    // RETI opcode decoder FSM (ED prefix seen or not)
    typedef enum logic {
        RS_IDLE = 1'b0,
        RS_ED   = 1'b1
    } reti_state_t;

    // RETI is the two-byte opcode ED 4D
    localparam logic [7:0] OP_ED = 8'hED;
    localparam logic [7:0] OP_4D = 8'h4D;

endpackage

// File: rtl/zint_prio.sv
// Fixed-priority encoder: bit 0 is the highest priority.
// Reports whether any request is set and the index of the winning one.
module zint_prio #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] i_req,
    output logic         o_any,
    output logic [W-1:0] o_idx
);

    // Scan from the lowest priority upward so the lowest set index wins last
    always_comb begin
        o_any = |i_req;
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/zint_ack.sv
// Z80 IM2 interrupt responder and prioritiser.
// Latches per-source request strobes, drives /INT, answers the INTACK cycle
// (M1 + IORQ, qualified on the Z80 clock falling edge) with an even IM2 vector
// and pulses int_ack on the source that was acknowledged.
// Optional feature macro: ZINT_RETI_EN builds an in-service mask and a RETI
// (ED 4D) decoder so that an active handler masks itself and all lower
// priority sources until it returns.
module zint_ack
    import zint_ack_pkg::*;
#(
    parameter int NSRC = NSRC_DEF,
    parameter int IDXW = IDXW_DEF
) (
    input  logic            i_fclk,
    input  logic            i_rst_n,
    input  logic            i_zpos,
    input  logic            i_zneg,
    input  logic            i_iorq_n,
    input  logic            i_m1_n,
    input  logic            i_mreq_n,
    input  logic [7:0]      i_din,
    input  logic [NSRC-1:0] i_int_req,
    input  logic [7:0]      i_vec_base,
    output logic            o_int_n,
    output logic            o_vec_oe,
    output logic [7:0]      o_vec_out,
    output logic [NSRC-1:0] o_int_ack
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    ack_state_t      r_state;
    logic [NSRC-1:0] r_pend;
    logic            r_int_n;
    logic            r_vec_oe;
    logic [7:0]      r_vec_out;
    logic [NSRC-1:0] r_int_ack;

    logic [NSRC-1:0] w_elig;
    logic            w_elig_any;
    logic [IDXW-1:0] w_elig_idx;
    logic [IDXW-1:0] w_vec_idx;
    logic            w_intack;
    logic [NSRC-1:0] w_ack_mask;

    // INTACK: M1 and IORQ both low, sampled on the Z80 clock falling edge
    assign w_intack = (r_state == ST_IDLE) && i_zneg && !i_iorq_n && !i_m1_n;

    // Only a real (non-spurious) acknowledge touches pend / isr / int_ack
    assign w_ack_mask = (w_intack && w_elig_any) ? (NSRC'(1) << w_elig_idx) : '0;

    // Spurious acknowledges answer with the all-ones index
    assign w_vec_idx = w_elig_any ? w_elig_idx : '1;

    // Winner among the eligible sources
    zint_prio #(
        .N (NSRC),
        .W (IDXW)
    ) u_prio_elig (
        .i_req (w_elig),
        .o_any (w_elig_any),
        .o_idx (w_elig_idx)
    );

`ifdef ZINT_RETI_EN
    // ------------------------------------------------------------------
    // In-service mask and RETI decoder
    // ------------------------------------------------------------------
    logic [NSRC-1:0] r_isr;
    reti_state_t     r_rstate;
    logic            w_isr_any;
    logic [IDXW-1:0] w_isr_idx;
    logic            w_fetch;
    logic            w_reti;
    logic [NSRC-1:0] w_isr_clr;
    logic            w_unused_ok;

    // Highest-priority source currently in service
    zint_prio #(
        .N (NSRC),
        .W (IDXW)
    ) u_prio_isr (
        .i_req (r_isr),
        .o_any (w_isr_any),
        .o_idx (w_isr_idx)
    );

    // A source is eligible only if it outranks every handler in service
    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_elig
            assign w_elig[gi] = r_pend[gi] &&
                                (!w_isr_any || (IDXW'(gi) < w_isr_idx));
        end
    endgenerate

    // Opcode fetch: M1 + MREQ with IORQ idle, data valid at Z80 rising edge
    assign w_fetch   = i_zpos && !i_m1_n && !i_mreq_n && i_iorq_n;
    assign w_reti    = w_fetch && (r_rstate == RS_ED) && (i_din == OP_4D);
    assign w_isr_clr = (w_reti && w_isr_any) ? (NSRC'(1) << w_isr_idx) : '0;

    // Low vector bits are replaced by the index field
    assign w_unused_ok = &{1'b0, i_vec_base[IDXW:0]};

    // In-service bits: set on acknowledge, highest one retired by RETI
    always_ff @(posedge i_fclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_isr <= '0;
        end else begin
            r_isr <= (r_isr & ~w_isr_clr) | w_ack_mask;
        end
    end

    // Track the ED prefix across opcode fetches; repeated ED keeps it armed
    always_ff @(posedge i_fclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rstate <= RS_IDLE;
        end else if (w_fetch) begin
            case (r_rstate)
                RS_IDLE: begin
                    if (i_din == OP_ED) begin
                        r_rstate <= RS_ED;
                    end
                end
                RS_ED: begin
                    if (i_din != OP_ED) begin
                        r_rstate <= RS_IDLE;
                    end
                end
                default: r_rstate <= RS_IDLE;
            endcase
        end
    end
`else
    // Without nesting every pending source may interrupt
    logic w_unused_ok;

    assign w_elig      = r_pend;
    assign w_unused_ok = &{1'b0, i_vec_base[IDXW:0], i_zpos, i_mreq_n, i_din};
`endif

    // ------------------------------------------------------------------
    // Pending requests: a new strobe wins over a same-cycle acknowledge
    // ------------------------------------------------------------------
    always_ff @(posedge i_fclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_ack_mask) | i_int_req;
        end
    end

    // ------------------------------------------------------------------
    // Acknowledge FSM with registered bus and /INT outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_fclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_int_n   <= 1'b1;
            r_vec_oe  <= 1'b0;
            r_vec_out <= '0;
            r_int_ack <= '0;
        end else begin
            r_int_ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    r_int_n <= ~w_elig_any;
                    if (w_intack) begin
                        r_state   <= ST_ACK;
                        r_int_n   <= 1'b1;
                        r_vec_oe  <= 1'b1;
                        r_vec_out <= {i_vec_base[7:IDXW+1], w_vec_idx, 1'b0};
                        r_int_ack <= w_ack_mask;
                    end
                end
                ST_ACK: begin
                    // Vector stays on the bus until the CPU releases IORQ
                    r_int_n <= 1'b1;
                    if (i_iorq_n) begin
                        r_state  <= ST_DONE;
                        r_vec_oe <= 1'b0;
                    end
                end
                ST_DONE: begin
                    // One-cycle gap before /INT may be asserted again
                    r_int_n <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_int_n  <= 1'b1;
                    r_vec_oe <= 1'b0;
                end
            endcase
        end
    end

    assign o_int_n   = r_int_n;
    assign o_vec_oe  = r_vec_oe;
    assign o_vec_out = r_vec_out;
    assign o_int_ack = r_int_ack;

endmodule
